// File: rtl/cache_pkg.sv
// Shared definitions for the cache miss-fill logic: state encoding,
// block geometry and a small sizing helper for the fill counters.
package cache_pkg;

  // Two-state fill controller: waiting for a miss, or filling a block.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_e;

  // Block geometry of both caches.
  localparam int unsigned BLOCK_BYTES     = 16;
  localparam int unsigned WORD_BYTES      = 2;
  localparam int unsigned WORDS_PER_BLOCK = BLOCK_BYTES / WORD_BYTES;
  localparam int unsigned OFFSET_W        = $clog2(BLOCK_BYTES);

  // Default bus widths.
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;

  // Bits needed for a counter that must be able to hold the value 'terminal'.
  function automatic int unsigned count_width(input int unsigned terminal);
    return $clog2(terminal + 32'd1);
  endfunction

endpackage

// File: rtl/cache_fill_fsm_fill_counter.sv
// Up-counter used by the fill controller to track issued requests and
// received words. Clear has priority over enable; the terminal flag is
// a pure compare on the current count.
module fill_counter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned TERMINAL = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o
);

  localparam logic [WIDTH-1:0] TC_VAL  = WIDTH'(TERMINAL);
  localparam logic [WIDTH-1:0] ONE_VAL = WIDTH'(32'd1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear wins, otherwise step on enable, otherwise hold.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + ONE_VAL;
    end else begin
      count_d = count_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == TC_VAL);

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss handler: on a miss, issues one read per cycle for every word
// of the missing block, streams the in-order returns into the data array,
// and writes tag/valid together with the last word. fsm_busy stalls the
// pipeline from the miss cycle itself until the fill completes.
module cache_fill_fsm #(
  parameter int unsigned WORDS_PER_BLOCK = cache_pkg::WORDS_PER_BLOCK,
  parameter int unsigned ADDR_W          = cache_pkg::ADDR_W,
  parameter int unsigned DATA_W          = cache_pkg::DATA_W
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               miss_detected,
  input  logic [ADDR_W-1:0]                  miss_address,
  output logic                               fsm_busy,
  output logic [ADDR_W-1:0]                  memory_address,
  output logic                               mem_read,
  input  logic                               memory_data_valid,
  input  logic [DATA_W-1:0]                  memory_data,
  output logic                               write_data_array,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word_offset,
  output logic [DATA_W-1:0]                  fill_data,
  output logic                               write_tag_array
);

  import cache_pkg::*;

  // Word index width, and counter widths: the issue counter must reach
  // WORDS_PER_BLOCK (all issued), the receive counter only the last index.
  localparam int unsigned IDX_W     = $clog2(WORDS_PER_BLOCK);
  localparam int unsigned ISSUE_W   = count_width(WORDS_PER_BLOCK);
  localparam int unsigned RECV_W    = count_width(WORDS_PER_BLOCK - 32'd1);
  localparam int unsigned ADDR_PAD  = ADDR_W - ISSUE_W - 1;
  localparam int unsigned BLK_BYTES = WORDS_PER_BLOCK * WORD_BYTES;

  // Byte-offset-within-block bits; cleared to form the block base.
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(BLK_BYTES - 32'd1);

  fill_state_e          state_q;
  fill_state_e          state_d;
  logic [ADDR_W-1:0]    base_q;
  logic [ADDR_W-1:0]    base_d;

  logic                 issue_clr_s;
  logic                 issue_en_s;
  logic [ISSUE_W-1:0]   issue_cnt_s;
  logic                 issue_done_s;

  logic                 recv_clr_s;
  logic                 recv_en_s;
  logic [RECV_W-1:0]    recv_cnt_s;
  logic                 recv_last_s;

  logic [ADDR_W-1:0]    word_byte_off_s;
  logic [ADDR_W-1:0]    miss_base_s;

  // Requests issued so far in the current fill; terminal = all issued.
  fill_counter #(
    .WIDTH    (ISSUE_W),
    .TERMINAL (WORDS_PER_BLOCK)
  ) u_issue_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (issue_clr_s),
    .en_i    (issue_en_s),
    .count_o (issue_cnt_s),
    .tc_o    (issue_done_s)
  );

  // Words received so far; terminal = the next return is the last word.
  fill_counter #(
    .WIDTH    (RECV_W),
    .TERMINAL (WORDS_PER_BLOCK - 32'd1)
  ) u_recv_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (recv_clr_s),
    .en_i    (recv_en_s),
    .count_o (recv_cnt_s),
    .tc_o    (recv_last_s)
  );

  // Byte offset of the word being requested (word index * 2). The sum with
  // the base is taken at ADDR_W bits so a block at the top of memory wraps
  // modulo 2^ADDR_W rather than widening.
  assign word_byte_off_s = {{ADDR_PAD{1'b0}}, issue_cnt_s, 1'b0};
  assign miss_base_s     = miss_address & ~LOW_MASK;

  // Returned data goes straight to the data array; the write strobe decides.
  assign fill_data = memory_data;

  // Next-state, counter control and all combinational outputs.
  always_comb begin
    state_d          = state_q;
    base_d           = base_q;
    fsm_busy         = 1'b0;
    mem_read         = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    fill_word_offset = '0;
    write_tag_array  = 1'b0;
    issue_clr_s      = 1'b0;
    issue_en_s       = 1'b0;
    recv_clr_s       = 1'b0;
    recv_en_s        = 1'b0;

    case (state_q)
      IDLE: begin
        // Stall in the miss cycle itself; returns arriving here are ignored.
        fsm_busy    = miss_detected;
        issue_clr_s = 1'b1;
        recv_clr_s  = 1'b1;
        if (miss_detected) begin
          state_d = FILL;
          base_d  = miss_base_s;
        end else begin
          state_d = IDLE;
        end
      end

      FILL: begin
        fsm_busy = 1'b1;

        // Request side: one word address per cycle until all are issued.
        if (!issue_done_s) begin
          mem_read       = 1'b1;
          memory_address = base_q + word_byte_off_s;
          issue_en_s     = 1'b1;
        end else begin
          mem_read       = 1'b0;
        end

        // Return side: words come back in request order.
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          fill_word_offset = recv_cnt_s[IDX_W-1:0];
          recv_en_s        = 1'b1;
          if (recv_last_s) begin
            write_tag_array = 1'b1;
            state_d         = IDLE;
          end else begin
            state_d         = FILL;
          end
        end else begin
          state_d = FILL;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latched block base; reset drops any fill in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: a pipelined memory model with configurable
// latency answers requests in order; each fill is checked at transaction
// level against the expected block addresses, word writes, tag pulse and
// total stall length.
module tb_cache_fill_fsm;

  localparam int WPB = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        fsm_busy;
  logic [15:0] memory_address;
  logic        mem_read;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        write_data_array;
  logic [2:0]  fill_word_offset;
  logic [15:0] fill_data;
  logic        write_tag_array;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Memory model state.
  int          gcyc    = 0;
  int          mem_lat = 3;
  int          req_idx = 0;
  logic [15:0] dbase   = 16'h0000;
  int          pend_due[$];
  logic [15:0] pend_dat[$];

  // Outputs sampled in the current cycle.
  logic        s_busy, s_rd, s_wr, s_tag;
  logic [15:0] s_addr, s_data;
  logic [2:0]  s_off;

  int t_a, t_b, t_x;

  cache_fill_fsm dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .fsm_busy          (fsm_busy),
    .memory_address    (memory_address),
    .mem_read          (mem_read),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .write_data_array  (write_data_array),
    .fill_word_offset  (fill_word_offset),
    .fill_data         (fill_data),
    .write_tag_array   (write_tag_array)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One clock cycle: drive inputs at the falling edge, let the memory model
  // answer, sample outputs, and record any new request.
  task automatic cycle(input logic miss, input logic [15:0] maddr, input logic r);
    @(negedge clk);
    miss_detected = miss;
    miss_address  = maddr;
    rst           = r;
    if (pend_due.size() > 0 && pend_due[0] == gcyc) begin
      memory_data_valid = 1'b1;
      memory_data       = pend_dat.pop_front();
      void'(pend_due.pop_front());
    end else begin
      memory_data_valid = 1'b0;
      memory_data       = 16'($urandom);
    end
    #1;
    s_busy = fsm_busy;
    s_rd   = mem_read;
    s_addr = memory_address;
    s_wr   = write_data_array;
    s_off  = fill_word_offset;
    s_data = fill_data;
    s_tag  = write_tag_array;
    if (mem_read) begin
      pend_due.push_back(gcyc + mem_lat);
      pend_dat.push_back(dbase + 16'(req_idx));
      req_idx++;
    end
    gcyc++;
  endtask

  task automatic idle_cycles(input int n, input logic [15:0] maddr);
    for (int i = 0; i < n; i++) begin
      cycle(1'b0, maddr, 1'b0);
      check_eq("idle_quiet", {s_busy, s_rd, s_wr, s_tag}, 32'd0);
    end
  endtask

  // One complete miss: hold miss_detected until the tag pulse (or reset
  // after rst_after returns when rst_after >= 0).
  task automatic run_fill(input logic [15:0] maddr, input int lat, input logic [15:0] db,
                          input bit chg, input int rst_after, output int tag_at);
    logic [15:0] base;
    int c, nbusy, nreq, nwr, ntag;
    bit fin, rst_now;
    base = maddr & 16'hFFF0;
    c = 0; nbusy = 0; nreq = 0; nwr = 0; ntag = 0;
    fin = 1'b0; rst_now = 1'b0; tag_at = -1;
    mem_lat = lat; dbase = db; req_idx = 0;
    while (!fin && c < 64) begin
      if (rst_now) begin
        cycle(1'b0, maddr, 1'b1);
        cycle(1'b0, maddr, 1'b0);
        check_eq("rst_idle", {s_busy, s_rd, s_wr, s_tag}, 32'd0);
        fin = 1'b1;
      end else begin
        cycle(1'b1, (chg && c >= 3) ? 16'h0000 : maddr, 1'b0);
        if (s_busy) nbusy++;
        if (s_rd) begin
          check_eq("req_addr", s_addr, base + 16'(2 * nreq));
          check_eq("req_slot", c, nreq + 1);
          nreq++;
        end
        if (s_wr) begin
          check_eq("wr_offset", s_off, nwr);
          check_eq("wr_data", s_data, db + 16'(nwr));
          nwr++;
        end
        if (s_tag) begin
          ntag++;
          check_eq("tag_with_last", {s_wr, s_off}, {1'b1, 3'd7});
          tag_at = gcyc - 1;
          fin = 1'b1;
        end
        if (rst_after >= 0 && nwr >= rst_after) rst_now = 1'b1;
        c++;
      end
    end
    check_eq("fill_done", fin, 32'd1);
    if (rst_after < 0) begin
      check_eq("req_count", nreq, WPB);
      check_eq("wr_count", nwr, WPB);
      check_eq("tag_count", ntag, 32'd1);
      check_eq("busy_cycles", nbusy, lat + 9);
    end else begin
      for (int k = 0; k < 16 && pend_due.size() > 0; k++) begin
        cycle(1'b0, maddr, 1'b0);
        check_eq("post_rst_quiet", {s_rd, s_wr, s_tag}, 32'd0);
      end
      check_eq("rst_no_tag", ntag, 32'd0);
      check_eq("rst_drained", pend_due.size(), 32'd0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; miss_detected = 1'b0; miss_address = 16'h0000;
    memory_data_valid = 1'b0; memory_data = 16'h0000;
    cycle(1'b0, 16'h0000, 1'b1);
    cycle(1'b0, 16'h0000, 1'b1);
    cycle(1'b0, 16'h0000, 1'b0);
    check_eq("reset_flags", {s_busy, s_rd, s_wr, s_tag}, 32'd0);
    check_eq("reset_addr", s_addr, 32'd0);
    check_eq("reset_offset", s_off, 32'd0);

    // Directed: 4-cycle memory (answer three cycles after the request).
    run_fill(16'h1236, 3, 16'hA000, 1'b0, -1, t_x);
    idle_cycles(2, 16'h1236);

    // Reset after the third return, then a normal fill.
    run_fill(16'h2468, 3, 16'hB000, 1'b0, 3, t_x);
    run_fill(16'h0040, 3, 16'hC000, 1'b0, -1, t_x);
    idle_cycles(1, 16'h0040);

    // Stray return while idle.
    pend_due.push_back(gcyc);
    pend_dat.push_back(16'hDEAD);
    idle_cycles(2, 16'h0000);

    // Top-of-memory block, miss_address changed mid-fill.
    run_fill(16'hFFF8, 4, 16'($urandom), 1'b1, -1, t_x);
    idle_cycles(1, 16'h0000);

    // Back-to-back misses.
    run_fill(16'h0100, 3, 16'h1100, 1'b0, -1, t_a);
    run_fill(16'h0200, 3, 16'h2200, 1'b0, -1, t_b);
    check_eq("b2b_tag_gap", t_b - t_a, 32'd12);
    idle_cycles(1, 16'h0000);

    // Randomized fills: address, latency, data, mid-fill address change,
    // occasional reset.
    for (int n = 0; n < 12; n++) begin
      logic [15:0] a;
      int lat, rs;
      a   = 16'($urandom);
      lat = $urandom_range(1, 6);
      rs  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : -1;
      run_fill(a, lat, 16'($urandom), 1'($urandom_range(0, 1)), rs, t_x);
      idle_cycles(1, a);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
